// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit, one radix-2 step per cycle.
// Define MULDIV_ZERO_SKIP_EN to finish multiplies by zero early.
module muldiv_unit #(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       funct,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             kill,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Out
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    localparam logic [WIDTH-1:0] MIN  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONES = '1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       funct_q, funct_d;
    logic [WIDTH-1:0] opd_q, opd_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             neg_q, neg_d;
    logic             sa_q, sa_d;

    logic             accept, is_div, sgn_a, sgn_b;
    logic             div_zero, div_ovf, mul_zero, special;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   mul_hi, div_shl, div_sub;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0] quo_fix, rem_fix, result;

    assign in_ready  = (state_q == IDLE) & ~kill;
    assign out_valid = (state_q == DONE);
    assign Out       = out_q;
    assign accept    = in_valid & in_ready;
    assign is_div    = funct[2];

    // Unsigned A: MULHU/DIVU/REMU. Unsigned B: additionally MULHSU.
    assign sgn_a = A[WIDTH-1] & ~(funct[0] & (funct[1] | funct[2]));
    assign sgn_b = B[WIDTH-1] & ~(funct[2] ? funct[0] : funct[1]);
    assign a_mag = sgn_a ? -A : A;
    assign b_mag = sgn_b ? -B : B;

    assign div_zero = is_div & (B == '0);
    assign div_ovf  = is_div & ~funct[0] & (A == MIN) & (B == ONES);
`ifdef MULDIV_ZERO_SKIP_EN
    assign mul_zero = ~is_div & ((A == '0) | (B == '0));
`else
    assign mul_zero = 1'b0;
`endif
    assign special = div_zero | div_ovf | mul_zero;

    // Multiply keeps {acc,lo} as the product; divide keeps acc=rem, lo=quo.
    assign mul_hi  = lo_q[0] ? ({1'b0, acc_q} + {1'b0, opd_q})
                             : {1'b0, acc_q};
    assign div_shl = {acc_q, lo_q[WIDTH-1]};
    assign div_sub = div_shl - {1'b0, opd_q};

    assign prod     = {acc_q, lo_q};
    assign prod_fix = neg_q ? -prod : prod;
    assign quo_fix  = neg_q ? -lo_q : lo_q;
    assign rem_fix  = sa_q ? -acc_q : acc_q;

    always_comb begin
        result = '0;
        unique case (1'b1)
            funct_q[2] & funct_q[1]:          result = rem_fix;
            funct_q[2] & ~funct_q[1]:         result = quo_fix;
            ~funct_q[2] & (funct_q[1:0] == 2'b00):
                result = prod_fix[WIDTH-1:0];
            ~funct_q[2] & (funct_q[1:0] != 2'b00):
                result = prod_fix[2*WIDTH-1:WIDTH];
            default:                          result = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        funct_d = funct_q;
        opd_d   = opd_q;
        acc_d   = acc_q;
        lo_d    = lo_q;
        out_d   = out_q;
        neg_d   = neg_q;
        sa_d    = sa_q;
        if (kill && state_q != IDLE) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        funct_d = funct;
                        cnt_d   = '0;
                        acc_d   = '0;
                        sa_d    = sgn_a;
                        neg_d   = sgn_a ^ sgn_b;
                        opd_d   = is_div ? b_mag : a_mag;
                        lo_d    = is_div ? a_mag : b_mag;
                        state_d = special ? FIX : CALC;
                        if (div_zero) begin
                            acc_d = A;
                            lo_d  = ONES;
                        end else if (div_ovf) begin
                            lo_d = A;
                        end else if (mul_zero) begin
                            lo_d = '0;
                        end
                        if (special) begin
                            neg_d = 1'b0;
                            sa_d  = 1'b0;
                        end
                    end
                end
                CALC: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (funct_q[2]) begin
                        if (!div_sub[WIDTH]) begin
                            acc_d = div_sub[WIDTH-1:0];
                            lo_d  = {lo_q[WIDTH-2:0], 1'b1};
                        end else begin
                            acc_d = div_shl[WIDTH-1:0];
                            lo_d  = {lo_q[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        acc_d = mul_hi[WIDTH:1];
                        lo_d  = {mul_hi[0], lo_q[WIDTH-1:1]};
                    end
                    if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIX;
                end
                FIX: begin
                    out_d   = result;
                    state_d = DONE;
                end
                DONE: begin
                    if (out_ready) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            funct_q <= '0;
            opd_q   <= '0;
            acc_q   <= '0;
            lo_q    <= '0;
            out_q   <= '0;
            neg_q   <= 1'b0;
            sa_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            funct_q <= funct_d;
            opd_q   <= opd_d;
            acc_q   <= acc_d;
            lo_q    <= lo_d;
            out_q   <= out_d;
            neg_q   <= neg_d;
            sa_q    <= sa_d;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed table, corner sequences
// and random operations against an arithmetic reference model.
module tb_muldiv_unit;

    localparam int W = 32;
`ifdef MULDIV_ZERO_SKIP_EN
    localparam int ZLAT = 2;
`else
    localparam int ZLAT = W + 2;
`endif
    localparam logic [W-1:0] MINV = 32'h8000_0000;

    logic         Clock = 1'b0;
    logic         Reset_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         kill = 1'b0;
    logic         out_ready = 1'b0;
    logic [2:0]   funct = '0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] Out;

    int checks = 0;
    int errors = 0;

    always #5 Clock = ~Clock;

    muldiv_unit #(.WIDTH(W)) dut (
        .Clock    (Clock),
        .Reset_n  (Reset_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .funct    (funct),
        .A        (A),
        .B        (B),
        .kill     (kill),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .Out      (Out)
    );

    typedef struct {
        string        name;
        logic [2:0]   f;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp;
        int           lat;
    } vec_t;

    vec_t tbl[17];

    task automatic chk(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic reset_pulse();
        #2 Reset_n = 1'b0;
        #10 Reset_n = 1'b1;
        tick();
    endtask

    // Reference arithmetic straight from the RV32M definitions.
    function automatic logic [W-1:0] model(input logic [2:0] f,
                                           input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        longint          sa, sb, p;
        longint unsigned ua, ub, pu;
        int              ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        ia = $signed(a);
        ib = $signed(b);
        case (f)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin pu = ua * ub; return pu[63:32]; end
            3'd4: begin
                if (b == 0) return '1;
                if (a == MINV && b == '1) return a;
                return 32'(ia / ib);
            end
            3'd5: return (b == 0) ? '1 : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == MINV && b == '1) return '0;
                return 32'(ia % ib);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] f,
                                     input logic [W-1:0] a,
                                     input logic [W-1:0] b);
        if (f[2] && b == 0) return 2;
        if ((f == 3'd4 || f == 3'd6) && a == MINV && b == '1) return 2;
        if (!f[2] && (a == 0 || b == 0)) return ZLAT;
        return W + 2;
    endfunction

    function automatic logic [W-1:0] rnd_opd();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return 32'd1;
            2: return '1;
            3: return MINV;
            4: return 32'h7fff_ffff;
            5: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        chk({name, " idle"}, 32'(in_ready), 32'd1);
    endtask

    // Latency counts the accept edge as edge 1.
    task automatic run_op(input string name, input logic [2:0] f,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp, input int explat);
        int lat;
        bit busy_bad;
        wait_idle(name);
        in_valid = 1'b1;
        funct = f;
        A = a;
        B = b;
        tick();
        lat = 1;
        busy_bad = 1'b0;
        while (!out_valid && lat < 100) begin
            if (in_ready) busy_bad = 1'b1;
            in_valid = 1'($urandom);
            funct = 3'($urandom);
            A = $urandom;
            B = $urandom;
            tick();
            lat++;
        end
        in_valid = 1'b0;
        chk({name, " out"}, Out, exp);
        chk({name, " lat"}, 32'(lat), 32'(explat));
        chk({name, " busy"}, 32'(busy_bad), 32'd0);
        if (!out_valid) begin
            reset_pulse();
        end else begin
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            chk({name, " release"}, 32'(out_valid), 32'd0);
        end
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
        chk({name, " valid"}, 32'(out_valid), 32'd1);
    endtask

    initial begin
        logic [W-1:0] held;
        logic [W-1:0] ra, rb;
        logic [2:0]   rf;
        bit           seen;

        tbl = '{
            '{"mul",        3'd0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 34},
            '{"mulh",       3'd1, MINV,         MINV,          32'h4000_0000, 34},
            '{"mulhu",      3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34},
            '{"mulhsu",     3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34},
            '{"div",        3'd4, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 34},
            '{"rem",        3'd6, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 34},
            '{"divu",       3'd5, 32'd100,      32'd7,         32'd14,        34},
            '{"remu",       3'd7, 32'd100,      32'd7,         32'd2,         34},
            '{"divu0",      3'd5, 32'd5,        32'd0,         32'hFFFF_FFFF, 2},
            '{"rem0",       3'd6, 32'd5,        32'd0,         32'd5,         2},
            '{"div_ovf",    3'd4, MINV,         32'hFFFF_FFFF, MINV,          2},
            '{"rem_ovf",    3'd6, MINV,         32'hFFFF_FFFF, 32'd0,         2},
            '{"mul_za",     3'd0, 32'd0,        32'd12345,     32'd0,         ZLAT},
            '{"mulhu_zb",   3'd3, 32'hDEAD_BEEF, 32'd0,        32'd0,         ZLAT},
            '{"div_min1",   3'd4, MINV,         32'd1,         MINV,          34},
            '{"remu_big",   3'd7, 32'h1234_5678, 32'hFFFF_FFFF, 32'h1234_5678, 34},
            '{"div_s0",     3'd4, 32'd7,        32'd0,         32'hFFFF_FFFF, 2}
        };

        #3;
        chk("rst in_ready", 32'(in_ready), 32'd1);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst Out", Out, 32'd0);
        #20 Reset_n = 1'b1;
        tick();

        foreach (tbl[i])
            run_op(tbl[i].name, tbl[i].f, tbl[i].a, tbl[i].b,
                   tbl[i].exp, tbl[i].lat);

        // Output held in DONE, then back-to-back request.
        wait_idle("hold");
        in_valid = 1'b1; funct = 3'd5; A = 32'd100; B = 32'd7;
        tick();
        in_valid = 1'b0;
        wait_valid("hold");
        held = Out;
        chk("hold value", held, 32'd14);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold valid", 32'(out_valid), 32'd1);
            chk("hold stable", Out, held);
            chk("hold in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        in_valid = 1'b1; funct = 3'd7; A = 32'd100; B = 32'd7;
        tick();
        out_ready = 1'b0;
        chk("b2b released", 32'(out_valid), 32'd0);
        chk("b2b idle", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("b2b accepted", 32'(in_ready), 32'd0);
        wait_valid("b2b");
        chk("b2b out", Out, 32'd2);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Kill during CALC.
        wait_idle("kill_calc");
        in_valid = 1'b1; funct = 3'd0; A = 32'd9; B = 32'd9;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        kill = 1'b1;
        #1 chk("kill blocks ready", 32'(in_ready), 32'd0);
        tick();
        kill = 1'b0;
        #1 chk("kill_calc idle", 32'(in_ready), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 45; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        chk("kill_calc no valid", 32'(seen), 32'd0);

        // Kill in IDLE blocks the accept.
        kill = 1'b1;
        in_valid = 1'b1; funct = 3'd0; A = 32'd3; B = 32'd3;
        #1 chk("kill idle ready", 32'(in_ready), 32'd0);
        tick();
        kill = 1'b0;
        in_valid = 1'b0;
        #1 chk("kill idle no accept", 32'(in_ready), 32'd1);

        // Kill while the result is waiting.
        in_valid = 1'b1; funct = 3'd5; A = 32'd9; B = 32'd0;
        tick();
        in_valid = 1'b0;
        wait_valid("kill_done");
        kill = 1'b1;
        tick();
        kill = 1'b0;
        #1;
        chk("kill_done valid", 32'(out_valid), 32'd0);
        chk("kill_done idle", 32'(in_ready), 32'd1);

        // Asynchronous reset mid-CALC.
        wait_idle("arst");
        in_valid = 1'b1; funct = 3'd4; A = 32'd1000; B = 32'd3;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        #2 Reset_n = 1'b0;
        #1;
        chk("arst in_ready", 32'(in_ready), 32'd1);
        chk("arst out_valid", 32'(out_valid), 32'd0);
        chk("arst Out", Out, 32'd0);
        #10 Reset_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 45; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        chk("arst no valid", 32'(seen), 32'd0);

        // Random operations against the reference model.
        for (int i = 0; i < 150; i++) begin
            rf = 3'($urandom);
            ra = rnd_opd();
            rb = rnd_opd();
            run_op($sformatf("rnd%0d f%0d", i, rf), rf, ra, rb,
                   model(rf, ra, rb), model_lat(rf, ra, rb));
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
